// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the MIPS pipeline control slice.
//   FWD_*      : E-stage ALU operand forwarding selects
//   div_state_t: divider occupancy FSM states
//   REG_ZERO   : architectural zero register index (never forwarded/hazarded)
package mips_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/div_occupancy.sv
// div_occupancy: tracks how long a multi-cycle divide occupies the E stage.
// Ports:
//   clk, resetn  : clock, async active-low reset
//   div_e        : div/divu instruction present in E
//   except_m     : exception taken in M (aborts any divide)
//   memwait      : M-stage memory wait (freezes the countdown)
//   busy         : FSM in BUSY
//   done         : FSM in DONE (the divide leaves E this cycle)
//   div_stall    : divide is holding E and everything before it
module div_occupancy
  import mips_pkg::*;
#(
  parameter int unsigned DIV_LAT = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic div_e,
  input  logic except_m,
  input  logic memwait,
  output logic busy,
  output logic done,
  output logic div_stall
);

  localparam int unsigned CW = $clog2(DIV_LAT);
  localparam logic [CW-1:0] LOAD = CW'(DIV_LAT - 2);

  div_state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The issue cycle in IDLE plus the BUSY cycles make up DIV_LAT-1 stalled
  // cycles; DONE is the cycle on which the divide advances. With DIV_LAT=2
  // there are no BUSY cycles, so IDLE goes straight to DONE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (except_m) begin
      state_next = DIV_IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div_e && !memwait) begin
            if (LOAD == '0) begin
              state_next = DIV_DONE;
              cnt_next   = '0;
            end else begin
              state_next = DIV_BUSY;
              cnt_next   = LOAD;
            end
          end
        end
        DIV_BUSY: begin
          if (!memwait) begin
            if (cnt <= CW'(1)) begin
              state_next = DIV_DONE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt - CW'(1);
            end
          end
        end
        DIV_DONE: begin
          state_next = DIV_IDLE;
        end
        default: begin
          state_next = DIV_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state == DIV_BUSY);
    done      = (state == DIV_DONE);
    div_stall = ((state == DIV_IDLE) && div_e) || (state == DIV_BUSY);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding and stall/flush control for the
// 5-stage MIPS pipeline.
// Ports:
//   clk, resetn                 : clock, async active-low reset
//   rs_d, rt_d, rs_e, rt_e      : D/E-stage source registers
//   wreg_e/m/w, regwrite_e/m/w  : destination register and write enable per stage
//   memtoreg_e/m                : load in E / M
//   branch_d                    : branch compare in D
//   div_e                       : divide in E
//   dmem_req_m, dmem_ready_m    : M-stage memory access and completion
//   except_m                    : exception taken in M
//   fwd_a_e, fwd_b_e            : ALU operand selects (FWD_M / FWD_W / FWD_RF)
//   fwd_a_d, fwd_b_d            : branch-compare forward from M
//   stall_f/d/e/m               : hold stage register
//   flush_d/e/m/w               : bubble stage register
//   div_busy, div_done          : divider occupancy state
//   stall_cnt                   : saturating count of cycles with stall_f=1
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned AW      = 5,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned PERF_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AW-1:0]     rs_d,
  input  logic [AW-1:0]     rt_d,
  input  logic [AW-1:0]     rs_e,
  input  logic [AW-1:0]     rt_e,
  input  logic [AW-1:0]     wreg_e,
  input  logic [AW-1:0]     wreg_m,
  input  logic [AW-1:0]     wreg_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memtoreg_e,
  input  logic              memtoreg_m,
  input  logic              branch_d,
  input  logic              div_e,
  input  logic              dmem_req_m,
  input  logic              dmem_ready_m,
  input  logic              except_m,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic              div_busy,
  output logic              div_done,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic memwait;
  logic div_stall;
  logic lwstall;
  logic brstall;

  assign memwait = dmem_req_m && !dmem_ready_m;

  div_occupancy #(
    .DIV_LAT (DIV_LAT)
  ) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .div_e     (div_e),
    .except_m  (except_m),
    .memwait   (memwait),
    .busy      (div_busy),
    .done      (div_done),
    .div_stall (div_stall)
  );

  // Forwarding: the younger M result takes precedence over W.
  always_comb begin
    fwd_a_e = FWD_RF;
    if (rs_e != ZERO && regwrite_m && rs_e == wreg_m)      fwd_a_e = FWD_M;
    else if (rs_e != ZERO && regwrite_w && rs_e == wreg_w) fwd_a_e = FWD_W;

    fwd_b_e = FWD_RF;
    if (rt_e != ZERO && regwrite_m && rt_e == wreg_m)      fwd_b_e = FWD_M;
    else if (rt_e != ZERO && regwrite_w && rt_e == wreg_w) fwd_b_e = FWD_W;

    fwd_a_d = (rs_d != ZERO) && (rs_d == wreg_m) && regwrite_m && !memtoreg_m;
    fwd_b_d = (rt_d != ZERO) && (rt_d == wreg_m) && regwrite_m && !memtoreg_m;
  end

  always_comb begin
    lwstall = memtoreg_e && regwrite_e && (wreg_e != ZERO) &&
              ((rs_d == wreg_e) || (rt_d == wreg_e));
    brstall = branch_d &&
              ((regwrite_e && (wreg_e != ZERO) &&
                ((wreg_e == rs_d) || (wreg_e == rt_d))) ||
               (memtoreg_m && (wreg_m != ZERO) &&
                ((wreg_m == rs_d) || (wreg_m == rt_d))));
  end

  // Strict priority; a load-use stall under a divide stall is simply dropped
  // because D stays held and the check repeats once E advances.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (except_m) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
    end else if (memwait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (div_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (lwstall || brstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_f && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic        regwrite_e, regwrite_m, regwrite_w;
  logic        memtoreg_e, memtoreg_m, branch_d, div_e;
  logic        dmem_req_m, dmem_ready_m, except_m;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        fwd_a_d, fwd_b_d;
  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, flush_m, flush_w;
  logic        div_busy, div_done;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .AW      (5),
    .DIV_LAT (4),
    .PERF_W  (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .wreg_e       (wreg_e),
    .wreg_m       (wreg_m),
    .wreg_w       (wreg_w),
    .regwrite_e   (regwrite_e),
    .regwrite_m   (regwrite_m),
    .regwrite_w   (regwrite_w),
    .memtoreg_e   (memtoreg_e),
    .memtoreg_m   (memtoreg_m),
    .branch_d     (branch_d),
    .div_e        (div_e),
    .dmem_req_m   (dmem_req_m),
    .dmem_ready_m (dmem_ready_m),
    .except_m     (except_m),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .fwd_a_d      (fwd_a_d),
    .fwd_b_d      (fwd_b_d),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_d      (flush_d),
    .flush_e      (flush_e),
    .flush_m      (flush_m),
    .flush_w      (flush_w),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .stall_cnt    (stall_cnt)
  );

  // {stall f,d,e,m, flush d,e,m,w, busy, done}
  logic [9:0]  sf;
  // {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, stall f,d,e,m, flush d,e,m,w}
  logic [13:0] fw;
  assign sf = {stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w, div_busy, div_done};
  assign fw = {fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d,
               stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m, flush_w};

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic [2:0] rw;      // regwrite e,m,w
    logic [1:0] mtr;     // memtoreg e,m
    logic       br;
    logic [2:0] mem;     // dmem_req, dmem_ready, except
    logic [1:0] xa, xb;  // expected fwd_a_e, fwd_b_e
    logic [1:0] xd;      // expected fwd_a_d, fwd_b_d
    logic [3:0] xstall;  // expected stall f,d,e,m
    logic [3:0] xflush;  // expected flush d,e,m,w
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    wreg_e = '0; wreg_m = '0; wreg_w = '0;
    regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
    memtoreg_e = 1'b0; memtoreg_m = 1'b0; branch_d = 1'b0; div_e = 1'b0;
    dmem_req_m = 1'b0; dmem_ready_m = 1'b0; except_m = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive_idle();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 3'b000,2'b00,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b0000,4'b0000};
    vecs[1]  = '{5'd0,5'd0,5'd3,5'd3,5'd0,5'd3,5'd3, 3'b011,2'b00,1'b0,3'b000, 2'b10,2'b10,2'b00, 4'b0000,4'b0000};
    vecs[2]  = '{5'd0,5'd0,5'd3,5'd3,5'd0,5'd0,5'd3, 3'b011,2'b00,1'b0,3'b000, 2'b01,2'b01,2'b00, 4'b0000,4'b0000};
    vecs[3]  = '{5'd0,5'd0,5'd3,5'd7,5'd0,5'd7,5'd3, 3'b011,2'b00,1'b0,3'b000, 2'b01,2'b10,2'b00, 4'b0000,4'b0000};
    vecs[4]  = '{5'd0,5'd0,5'd3,5'd3,5'd0,5'd3,5'd3, 3'b000,2'b00,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b0000,4'b0000};
    vecs[5]  = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 3'b011,2'b00,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b0000,4'b0000};
    vecs[6]  = '{5'd4,5'd0,5'd0,5'd0,5'd4,5'd0,5'd0, 3'b100,2'b10,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b1100,4'b0100};
    vecs[7]  = '{5'd4,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 3'b100,2'b10,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b0000,4'b0000};
    vecs[8]  = '{5'd0,5'd4,5'd0,5'd0,5'd4,5'd0,5'd0, 3'b100,2'b10,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b1100,4'b0100};
    vecs[9]  = '{5'd5,5'd0,5'd0,5'd0,5'd5,5'd0,5'd0, 3'b100,2'b00,1'b1,3'b000, 2'b00,2'b00,2'b00, 4'b1100,4'b0100};
    vecs[10] = '{5'd5,5'd0,5'd0,5'd0,5'd0,5'd5,5'd0, 3'b010,2'b00,1'b1,3'b000, 2'b00,2'b00,2'b10, 4'b0000,4'b0000};
    vecs[11] = '{5'd0,5'd6,5'd0,5'd0,5'd0,5'd6,5'd0, 3'b010,2'b01,1'b1,3'b000, 2'b00,2'b00,2'b00, 4'b1100,4'b0100};
    vecs[12] = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 3'b000,2'b00,1'b0,3'b100, 2'b00,2'b00,2'b00, 4'b1111,4'b0001};
    vecs[13] = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 3'b000,2'b00,1'b0,3'b110, 2'b00,2'b00,2'b00, 4'b0000,4'b0000};
    vecs[14] = '{5'd4,5'd0,5'd0,5'd0,5'd4,5'd0,5'd0, 3'b100,2'b10,1'b0,3'b100, 2'b00,2'b00,2'b00, 4'b1111,4'b0001};
    vecs[15] = '{5'd4,5'd0,5'd0,5'd0,5'd4,5'd0,5'd0, 3'b100,2'b10,1'b0,3'b101, 2'b00,2'b00,2'b00, 4'b0000,4'b1110};
    vecs[16] = '{5'd5,5'd0,5'd0,5'd0,5'd5,5'd0,5'd0, 3'b100,2'b00,1'b0,3'b000, 2'b00,2'b00,2'b00, 4'b0000,4'b0000};
    vecs[17] = '{5'd0,5'd9,5'd0,5'd0,5'd9,5'd0,5'd0, 3'b100,2'b00,1'b1,3'b000, 2'b00,2'b00,2'b00, 4'b1100,4'b0100};

    resetn = 1'b0;
    drive_idle();
    #3;
    chk("reset_outputs", 32'({fw, div_busy, div_done}), 32'h0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Combinational vectors with the divider idle.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d;
      rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
      wreg_e = vecs[i].wreg_e; wreg_m = vecs[i].wreg_m; wreg_w = vecs[i].wreg_w;
      {regwrite_e, regwrite_m, regwrite_w} = vecs[i].rw;
      {memtoreg_e, memtoreg_m} = vecs[i].mtr;
      branch_d = vecs[i].br;
      {dmem_req_m, dmem_ready_m, except_m} = vecs[i].mem;
      div_e = 1'b0;
      #1;
      chk($sformatf("vec%0d", i), 32'(fw),
          32'({vecs[i].xa, vecs[i].xb, vecs[i].xd, vecs[i].xstall, vecs[i].xflush}));
    end

    // Load-use: one stall cycle, then the bubble lets the load reach M.
    reset_dut();
    @(negedge clk);
    memtoreg_e = 1'b1; regwrite_e = 1'b1; wreg_e = 5'd4; rs_d = 5'd4;
    #1 chk("lw_stall", 32'(sf), 32'b1100_0100_00);
    @(negedge clk);
    memtoreg_e = 1'b0; regwrite_e = 1'b0; wreg_e = 5'd0;
    wreg_m = 5'd4; regwrite_m = 1'b1; memtoreg_m = 1'b1;
    #1 chk("lw_release", 32'(sf), 32'h0);

    // Branch hazard, then M-stage branch forward.
    reset_dut();
    @(negedge clk);
    branch_d = 1'b1; rs_d = 5'd5; wreg_e = 5'd5; regwrite_e = 1'b1;
    #1 chk("br_stall", 32'(sf), 32'b1100_0100_00);
    @(negedge clk);
    wreg_e = 5'd0; regwrite_e = 1'b0; wreg_m = 5'd5; regwrite_m = 1'b1;
    #1 chk("br_fwd", 32'({fwd_a_d, fwd_b_d, sf}), 32'({2'b10, 10'h0}));

    // Divide, DIV_LAT=4.
    reset_dut();
    @(negedge clk); div_e = 1'b1;
    #1 chk("div_c0", 32'(sf), 32'b1110_0010_00);
    @(negedge clk); #1 chk("div_c1", 32'(sf), 32'b1110_0010_10);
    @(negedge clk); #1 chk("div_c2", 32'(sf), 32'b1110_0010_10);
    @(negedge clk); #1 chk("div_c3_done", 32'(sf), 32'b0000_0000_01);
    chk("div_stall_cnt", 32'(stall_cnt), 32'd3);
    @(negedge clk); div_e = 1'b0;
    #1 chk("div_idle", 32'(sf), 32'h0);

    // Divide interrupted by a two-cycle memory wait.
    reset_dut();
    @(negedge clk); div_e = 1'b1;
    #1 chk("mw_c0", 32'(sf), 32'b1110_0010_00);
    @(negedge clk); dmem_req_m = 1'b1;
    #1 chk("mw_wait0", 32'(sf), 32'b1111_0001_10);
    @(negedge clk); #1 chk("mw_wait1", 32'(sf), 32'b1111_0001_10);
    @(negedge clk); dmem_req_m = 1'b0;
    #1 chk("mw_resume", 32'(sf), 32'b1110_0010_10);
    @(negedge clk); #1 chk("mw_busy2", 32'(sf), 32'b1110_0010_10);
    @(negedge clk); #1 chk("mw_done", 32'(sf), 32'b0000_0000_01);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd5);
    @(negedge clk); div_e = 1'b0;

    // Exception during BUSY.
    reset_dut();
    @(negedge clk); div_e = 1'b1;
    #1 chk("exc_c0", 32'(sf), 32'b1110_0010_00);
    @(negedge clk); except_m = 1'b1;
    #1 chk("exc_flush", 32'(sf), 32'b0000_1110_10);
    @(negedge clk); except_m = 1'b0; div_e = 1'b0;
    #1 chk("exc_after", 32'(sf), 32'h0);

    // Asynchronous reset while BUSY.
    reset_dut();
    @(negedge clk); div_e = 1'b1;
    @(negedge clk); div_e = 1'b0;
    #1 chk("rst_busy", 32'(sf), 32'b1110_0010_10);
    #1 resetn = 1'b0;
    #1 chk("rst_async", 32'({fw, div_busy, div_done}), 32'h0);
    chk("rst_async_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk); resetn = 1'b1;

    // Stall counter saturation under a long memory wait.
    reset_dut();
    @(negedge clk); dmem_req_m = 1'b1;
    repeat (65534) @(negedge clk);
    #1 chk("cnt_fffe", 32'(stall_cnt), 32'hFFFE);
    @(negedge clk);
    #1 chk("cnt_ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (3) @(negedge clk);
    #1 chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
    dmem_req_m = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and pipeline-control unit for the 5-stage MIPS core.
- Generates E-stage and D-stage forwarding selects, plus per-stage stall and flush signals for:
  - load-use and branch-compare hazards;
  - multi-cycle divide occupancy;
  - variable-latency data-memory wait;
  - exception flush.
- Owns the divider-occupancy FSM and a saturating stall-cycle performance counter.
- Sits beside the datapath; all stage pipeline registers consume its stall/flush outputs.

Parameters:
- AW, 5, register-address width.
- DIV_LAT, 32, divider cycles from issue to result; legal range ≥2.
- PERF_W, 16, stall-counter width.

Ports:
- clk  in  1  clock.
- resetn  in  1  async active-low reset.
- rs_d, rt_d  in  AW  D-stage source regs.
- rs_e, rt_e  in  AW  E-stage source regs.
- wreg_e, wreg_m, wreg_w  in  AW  destination reg per stage.
- regwrite_e, regwrite_m, regwrite_w  in  1  write-enable per stage.
- memtoreg_e, memtoreg_m  in  1  load in E / M.
- branch_d  in  1  branch in D.
- div_e  in  1  div/divu in E.
- dmem_req_m  in  1  M-stage memory access active.
- dmem_ready_m  in  1  memory access complete this cycle.
- except_m  in  1  exception taken in M.
- fwd_a_e, fwd_b_e  out  2  ALU operand select: 10=M, 01=W, 00=regfile.
- fwd_a_d, fwd_b_d  out  1  branch-compare forward from M.
- stall_f, stall_d, stall_e, stall_m  out  1  hold stage register.
- flush_d, flush_e, flush_m, flush_w  out  1  bubble stage register.
- div_busy  out  1  FSM in BUSY.
- div_done  out  1  FSM in DONE.
- stall_cnt  out  PERF_W  cycles with stall_f=1, saturating.

Behaviour:
- Forwarding is combinational:
  - fwd_x_e: M match wins over W match; requires source≠0 and the matching regwrite.
  - fwd_x_d: source≠0 & source==wreg_m & regwrite_m & !memtoreg_m.
- lwstall = memtoreg_e & regwrite_e & wreg_e≠0 & (rs_d==wreg_e | rt_d==wreg_e).
- brstall = branch_d & ((regwrite_e & wreg_e≠0 & wreg_e∈{rs_d,rt_d}) | (memtoreg_m & wreg_m≠0 & wreg_m∈{rs_d,rt_d})).
- Divider FSM: states IDLE, BUSY, DONE; down-counter width $clog2(DIV_LAT).
  - IDLE→BUSY when div_e & !except_m & !memwait; counter loads DIV_LAT-2.
  - BUSY: counter decrements each cycle while !memwait (freezes during memwait); at 0 → DONE.
  - DONE→IDLE unconditionally after 1 cycle.
  - The div stays in E for exactly DIV_LAT cycles total: DIV_LAT-1 stalled cycles, then advances on the DONE cycle.
  - except_m in any state forces IDLE next cycle; counter is cleared.
- memwait = dmem_req_m & !dmem_ready_m.
- Priority, highest first; outputs not listed are 0:
  1. except_m: flush_d=flush_e=flush_m=1; no stalls.
  2. memwait: stall_f/d/e/m=1, flush_w=1.
  3. div stall, condition (IDLE & div_e) | BUSY: stall_f/d/e=1, flush_m=1.
  4. lwstall | brstall: stall_f/d=1, flush_e=1.
- A lwstall coincident with a div stall is absorbed by the div stall; it is re-evaluated when E advances.
- div_done=1 in DONE only; div_busy=1 in BUSY only.
- stall_cnt increments each cycle stall_f=1 and saturates at all-ones.
- Reset (async, resetn=0):
  - FSM=IDLE, counter=0, stall_cnt=0.
  - With idle inputs, every stall/flush/fwd output is 0.
  - Reset asserted mid-BUSY aborts the divide immediately.

Decomposition:
- Shared package (mips_pkg) holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - div FSM state enum;
  - REG_ZERO constant.
- One sub-module is natural: div_occupancy (FSM + counter, outputs busy/done/div_stall).
- Forwarding and priority logic stay flat in hazard_ctrl.

Test Plan:
- add r3 in M, sub uses rs_e=3 and rt_e=3, with r3 also pending in W → fwd_a_e=fwd_b_e=2'b10. Same with wreg_m=0 → 2'b01 from W.
- lw r4 in E, D-stage rs_d=4 → one cycle stall_f=stall_d=flush_e=1, then 0. Same with wreg_e=0 → no stall.
- DIV_LAT=4, div_e pulse held by stall:
  - stall_f/d/e=1 and flush_m=1 for 3 cycles; div_busy for 2 cycles; div_done on the 4th cycle.
  - stall_cnt +3.
- Div BUSY, then memwait for 2 cycles:
  - stall_m=flush_w=1 during memwait; counter frozen; div completes 2 cycles later.
  - stall_cnt saturates at 16'hFFFF under long memwait (PERF_W=16).
- except_m during BUSY → flush_d/e/m=1 that cycle; stalls 0; FSM IDLE next cycle; div_busy=0.
- beq rs_d=5 with add r5 in E → brstall. Next cycle r5 in M (non-load) → fwd_a_d=1, no stall. resetn low mid-BUSY → all outputs 0 asynchronously.
